// File: rtl/evolution_scheduler.sv
// Evolution scheduler: turns keyboard command levels into one-at-a-time engine
// handshakes, paces generations with a shift-scaled timer and counts them.
module evolution_scheduler #(
   parameter int unsigned P_BASE_TICKS = 781250,
   parameter int unsigned P_MAX_SHIFT  = 5
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        clear,
   input  logic        manual,
   input  logic [15:0] file_id,
   input  logic [3:0]  evo_left_shift,
   output logic        load_req,
   output logic [15:0] load_file_id,
   input  logic        load_done,
   output logic        clr_req,
   input  logic        clr_done,
   output logic        evo_req,
   input  logic        evo_done,
   output logic        running,
   output logic        edit_grant,
   output logic [31:0] generation,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_CLEAR    = 3'd2,
      S_RUN_WAIT = 3'd3,
      S_EVOLVE   = 3'd4,
      S_MANUAL   = 3'd5
   } state_t;

   // A 4-bit shift input can never exceed 15, so larger limits behave like 15.
   localparam logic [3:0]  LP_MAX_SHIFT = (P_MAX_SHIFT > 15) ? 4'd15 : 4'(P_MAX_SHIFT);
   localparam logic [31:0] LP_BASE      = 32'(P_BASE_TICKS);

   state_t      r_state, w_state_nxt;
   logic        r_start_q, r_pause_q, r_clear_q;
   logic        w_start_edge, w_pause_edge, w_clear_edge;
   logic [31:0] r_tick, w_tick_nxt;
   logic [15:0] r_loaded_id, r_load_file_id;
   logic        w_latch_id;
   logic        r_pend_pause, r_pend_clear, w_pend_pause, w_pend_clear;
   logic [3:0]  w_shift;
   logic [31:0] w_period_m1;
   logic        w_load_fire, w_clr_fire, w_evo_fire;
   logic        r_load_req, r_clr_req, r_evo_req, r_edit_grant, r_running;
   logic        w_load_req_nxt, w_clr_req_nxt, w_evo_req_nxt, w_edit_grant_nxt, w_running_nxt;
   logic [31:0] r_generation;

   assign w_start_edge = start & ~r_start_q;
   assign w_pause_edge = pause & ~r_pause_q;
   assign w_clear_edge = clear & ~r_clear_q;

   assign w_shift     = (evo_left_shift > LP_MAX_SHIFT) ? LP_MAX_SHIFT : evo_left_shift;
   assign w_period_m1 = (LP_BASE << w_shift) - 32'd1;

   assign w_load_fire  = r_load_req & load_done;
   assign w_clr_fire   = r_clr_req & clr_done;
   assign w_evo_fire   = r_evo_req & evo_done;
   assign w_pend_pause = r_pend_pause | w_pause_edge;
   assign w_pend_clear = r_pend_clear | w_clear_edge;

   always_ff @(posedge clk_in) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = '0;
      w_latch_id  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_clear_edge)                 w_state_nxt = S_CLEAR;
            else if (w_start_edge)            w_state_nxt = S_RUN_WAIT;
            else if (file_id != r_loaded_id) begin
               w_state_nxt = S_LOAD;
               w_latch_id  = 1'b1;
            end
            else if (manual)                  w_state_nxt = S_MANUAL;
         end
         S_LOAD:  if (w_load_fire) w_state_nxt = S_IDLE;
         S_CLEAR: if (w_clr_fire)  w_state_nxt = S_IDLE;
         S_RUN_WAIT: begin
            if (w_clear_edge)               w_state_nxt = S_CLEAR;
            else if (w_pause_edge)          w_state_nxt = S_IDLE;
            else if (r_tick >= w_period_m1) w_state_nxt = S_EVOLVE;
            else                            w_tick_nxt  = r_tick + 32'd1;
         end
         S_EVOLVE: begin
            if (w_evo_fire) begin
               if (w_pend_clear)      w_state_nxt = S_CLEAR;
               else if (w_pend_pause) w_state_nxt = S_IDLE;
               else                   w_state_nxt = S_RUN_WAIT;
            end
         end
         S_MANUAL: begin
            if (w_clear_edge)      w_state_nxt = S_CLEAR;
            else if (w_start_edge) w_state_nxt = S_RUN_WAIT;
            else if (!manual)      w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: outputs decode the next state and are registered, so they change
   // on the same edge as the state and cannot glitch or overlap.
   always_comb begin
      w_load_req_nxt   = (w_state_nxt == S_LOAD);
      w_clr_req_nxt    = (w_state_nxt == S_CLEAR);
      w_evo_req_nxt    = (w_state_nxt == S_EVOLVE);
      w_edit_grant_nxt = (w_state_nxt == S_MANUAL);
      w_running_nxt    = (w_state_nxt == S_RUN_WAIT) || (w_state_nxt == S_EVOLVE);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_start_q      <= 1'b0;
         r_pause_q      <= 1'b0;
         r_clear_q      <= 1'b0;
         r_tick         <= '0;
         r_loaded_id    <= 16'hFFFF;
         r_load_file_id <= '0;
         r_pend_pause   <= 1'b0;
         r_pend_clear   <= 1'b0;
         r_generation   <= '0;
         r_load_req     <= 1'b0;
         r_clr_req      <= 1'b0;
         r_evo_req      <= 1'b0;
         r_edit_grant   <= 1'b0;
         r_running      <= 1'b0;
      end else begin
         r_start_q <= start;
         r_pause_q <= pause;
         r_clear_q <= clear;
         r_tick    <= w_tick_nxt;
         if (w_latch_id)  r_load_file_id <= file_id;
         if (w_load_fire) r_loaded_id    <= r_load_file_id;
         // Commands arriving mid-evolve wait for the handshake to finish.
         if (r_state == S_EVOLVE && !w_evo_fire) begin
            r_pend_pause <= w_pend_pause;
            r_pend_clear <= w_pend_clear;
         end else begin
            r_pend_pause <= 1'b0;
            r_pend_clear <= 1'b0;
         end
         if (w_load_fire || w_clr_fire)                r_generation <= '0;
         else if (w_evo_fire && r_generation != '1)    r_generation <= r_generation + 32'd1;
         r_load_req   <= w_load_req_nxt;
         r_clr_req    <= w_clr_req_nxt;
         r_evo_req    <= w_evo_req_nxt;
         r_edit_grant <= w_edit_grant_nxt;
         r_running    <= w_running_nxt;
      end
   end

   assign load_req     = r_load_req;
   assign load_file_id = r_load_file_id;
   assign clr_req      = r_clr_req;
   assign evo_req      = r_evo_req;
   assign edit_grant   = r_edit_grant;
   assign running      = r_running;
   assign generation   = r_generation;
   assign state        = r_state;

endmodule

// File: doc/evolution_scheduler.md
Name: evolution_scheduler

Overview:
Sequences the cell-array datapath from the keyboard controller's command levels (start/pause/clear/manual/file_id/evo_left_shift). It issues one-at-a-time req/done handshakes to three engines: pattern loader, array clearer and one-generation evolve engine. It paces evolution with a generation timer, counts generations and arbitrates so that at most one engine owns the cell memory at any time.

Parameters:
P_BASE_TICKS, 781250, clk_in cycles per generation at evo_left_shift=0 (must be >=1)
P_MAX_SHIFT, 5, evo_left_shift values above this are clamped to it

Ports:
clk_in  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
start  input  1  command level from keyboard controller; may stay high for up to 65536 cycles
pause  input  1  command level, same holding rule as start
clear  input  1  command level, same holding rule as start
manual  input  1  manual-edit mode level
file_id  input  16  selected pattern
evo_left_shift  input  4  speed exponent; period = P_BASE_TICKS << min(evo_left_shift, P_MAX_SHIFT)
load_req  output  1  loader request
load_file_id  output  16  pattern to load, valid while load_req=1
load_done  input  1  loader completion pulse
clr_req  output  1  clearer request
clr_done  input  1  clearer completion pulse
evo_req  output  1  evolve-one-generation request
evo_done  input  1  evolve completion pulse
running  output  1  high in RUN_WAIT and EVOLVE
edit_grant  output  1  manual editor may write the cell memory
generation  output  32  generations since last load/clear
state  output  3  FSM state encoding, for debug

Behaviour:
- Reset, synchronous and active-high, is sampled every clk_in edge. All outputs go to 0. FSM goes to IDLE, tick counter to 0, edge registers to 0, loaded_id to 16'hFFFF. This forces a load of the current file_id after reset.
- Reset mid-handshake drops the req immediately. A done pulse arriving in the cycle after reset is ignored.
- start, pause and clear are rising-edge detected against their previous-cycle registered value. Holding a level high never re-triggers.
- States: IDLE=0, LOAD=1, CLEAR=2, RUN_WAIT=3, EVOLVE=4, MANUAL=5.
- IDLE. Priority on the same cycle is clear_edge > start_edge > (file_id != loaded_id) > manual.
  - clear_edge -> CLEAR.
  - start_edge -> RUN_WAIT, tick counter 0.
  - file_id != loaded_id -> LOAD, latch load_file_id = file_id.
  - manual=1 -> MANUAL.
  - pause_edge is ignored.
- LOAD. load_req=1 until the cycle load_done=1 is sampled, then load_req drops next cycle. On done: loaded_id <= load_file_id, generation <= 0, -> IDLE. file_id changes during LOAD are handled by the IDLE compare afterwards.
- CLEAR. clr_req handshake, same rules as LOAD. On done: generation <= 0, -> IDLE.
- RUN_WAIT. Tick counter increments each cycle.
  - When counter >= period-1: counter <= 0, -> EVOLVE.
  - A period change takes effect immediately. If the counter already exceeds the new period, EVOLVE is entered next cycle.
  - clear_edge -> CLEAR (priority). pause_edge -> IDLE. file_id changes are ignored while running.
- EVOLVE. evo_req handshake, same rules as LOAD.
  - pause_edge or clear_edge seen during EVOLVE is latched into pending flags. The active handshake is never aborted.
  - On evo_done: generation += 1, saturating at 32'hFFFFFFFF.
  - Exit: pending clear -> CLEAR; pending pause -> IDLE; otherwise -> RUN_WAIT with counter 0. Pending flags clear on exit.
- MANUAL. edit_grant=1.
  - manual=0 -> IDLE.
  - start_edge -> RUN_WAIT (edit_grant drops same transition).
  - clear_edge -> CLEAR.
- Exclusivity: at most one of load_req, clr_req, evo_req, edit_grant is high in any cycle. All four are registered outputs.
- Done pulses sampled while the matching req is low are ignored.
- Width rules:
  - Shift is clamped to P_MAX_SHIFT before use.
  - The period is computed in 32 bits.
  - The tick counter is 32-bit unsigned.

Test Plan:
- P_BASE_TICKS=4. Release reset with file_id=3 -> load_req rises within 2 cycles, load_file_id=3. load_done pulse -> load_req low next cycle, state=IDLE, generation=0.
- Loaded, evo_left_shift=1, start held high for 100 cycles -> exactly one RUN_WAIT entry. evo_req rises every 8+handshake cycles. Bench returns evo_done 3 cycles after each req -> generation counts 1,2,3 with no double increments.
- pause edge 1 cycle after evo_req rises -> evo_req remains high until evo_done. Then generation increments once, state=IDLE, running=0.
- start_edge and clear_edge in the same IDLE cycle -> state=CLEAR, clr_req=1. clr_done -> generation=0, IDLE.
- manual=1 in IDLE -> edit_grant=1. Change file_id to 7 -> no load_req. manual=0 -> IDLE, then LOAD with load_file_id=7.
- evo_left_shift=9 -> period clamps to 4<<5=128 cycles. Drop to shift 0 at counter=50 -> EVOLVE next cycle. Assert reset during EVOLVE -> all reqs 0 and generation=0 the next cycle.
